// File: rtl/msdf_mul_sched_if.sv
// rtl/msdf_mul_sched_if.sv - request/grant and datapath-control bundle for msdf_mul_sched
interface msdf_mul_sched_if;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       dp_clear;
  logic       load_x;
  logic       ready_zj;
  logic       zj_last;
  logic [7:0] digit_idx;
  logic [1:0] done;
  logic       busy;

  modport master (
    output req,
    input  gnt, dp_clear, load_x, ready_zj, zj_last, digit_idx, done, busy
  );

  modport slave (
    input  req,
    output gnt, dp_clear, load_x, ready_zj, zj_last, digit_idx, done, busy
  );
endinterface

// File: rtl/msdf_mul_sched.sv
// rtl/msdf_mul_sched.sv - round-robin scheduler sharing one online (MSDF) serial multiplier
// Every output is a flop whose next value is decoded from the next state and next count.
module msdf_mul_sched #(
  parameter int N     = 9,
  parameter int DELTA = 3
) (
  input  logic           clk,
  input  logic           rst,
  msdf_mul_sched_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DONE} state_t;

  localparam logic [7:0] FEED_LAST  = 8'(N - 1);
  localparam logic [7:0] FLUSH_LAST = 8'(N + DELTA - 1);
  localparam logic [7:0] FIRST_Z    = 8'(DELTA);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       p_q, p_d;
  logic       win_q, win_d;
  logic [1:0] gnt_q, gnt_d;
  logic       dp_clear_q, dp_clear_d;
  logic       load_x_q, load_x_d;
  logic       ready_zj_q, ready_zj_d;
  logic       zj_last_q, zj_last_d;
  logic [7:0] digit_idx_q, digit_idx_d;
  logic [1:0] done_q, done_d;
  logic       busy_q, busy_d;
  logic       digit_phase;
  logic [1:0] win_onehot;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (|bus.req) begin
          state_d = S_CLEAR;
          win_d   = bus.req[p_q] ? p_q : ~p_q;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = 8'd0;
      end
      S_FEED: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == FEED_LAST) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = S_DONE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Fairness: the pointer moves away from the requester just served.
    if (state_d == S_DONE && state_q != S_DONE) p_d = ~win_q;

    digit_phase = (state_d == S_FEED) || (state_d == S_FLUSH);
    win_onehot  = win_d ? 2'b10 : 2'b01;

    gnt_d       = (state_d != S_IDLE) ? win_onehot : 2'b00;
    dp_clear_d  = (state_d == S_CLEAR);
    load_x_d    = (state_d == S_FEED);
    digit_idx_d = digit_phase ? cnt_d : 8'd0;
    // Result digits trail operand digits by the multiplier's online delay.
    ready_zj_d  = digit_phase && (cnt_d >= FIRST_Z) && (cnt_d <= FLUSH_LAST);
    zj_last_d   = digit_phase && (cnt_d == FLUSH_LAST);
    done_d      = (state_d == S_DONE) ? win_onehot : 2'b00;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      p_q         <= 1'b0;
      win_q       <= 1'b0;
      gnt_q       <= 2'b00;
      dp_clear_q  <= 1'b0;
      load_x_q    <= 1'b0;
      ready_zj_q  <= 1'b0;
      zj_last_q   <= 1'b0;
      digit_idx_q <= 8'd0;
      done_q      <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      dp_clear_q  <= dp_clear_d;
      load_x_q    <= load_x_d;
      ready_zj_q  <= ready_zj_d;
      zj_last_q   <= zj_last_d;
      digit_idx_q <= digit_idx_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.dp_clear  = dp_clear_q;
  assign bus.load_x    = load_x_q;
  assign bus.ready_zj  = ready_zj_q;
  assign bus.zj_last   = zj_last_q;
  assign bus.digit_idx = digit_idx_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_msdf_mul_sched.sv
// tb/tb_msdf_mul_sched.sv - scoreboard bench for msdf_mul_sched with N=9, DELTA=3
module tb_msdf_mul_sched;
  localparam int N     = 9;
  localparam int DELTA = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  msdf_mul_sched_if bus();
  msdf_mul_sched #(.N(N), .DELTA(DELTA)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];
  bit gap_chk = 1'b0;
  bit p_model;

  wire logic [16:0] snap = {bus.gnt, bus.dp_clear, bus.load_x, bus.ready_zj, bus.zj_last,
                            bus.done, bus.busy, bus.digit_idx};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Expected single-operation timeline, k cycles after the arbitrating edge.
  function automatic logic [16:0] exp_vec(input int k);
    logic [1:0] g = 2'b00, d = 2'b00;
    logic dpc = 1'b0, ld = 1'b0, rd = 1'b0, ls = 1'b0, bz = 1'b0;
    logic [7:0] ix = 8'd0;
    if (k >= 1 && k <= 14) begin g = 2'b01; bz = 1'b1; end
    if (k == 1) dpc = 1'b1;
    if (k >= 2 && k <= 10) ld = 1'b1;
    if (k >= 2 && k <= 13) ix = 8'(k - 2);
    if (k >= 5 && k <= 13) rd = 1'b1;
    if (k == 13) ls = 1'b1;
    if (k == 14) d = 2'b01;
    return {g, dpc, ld, rd, ls, d, bz, ix};
  endfunction

  // Monitor: per-operation digit accounting, popped against the scoreboard on done.
  initial begin
    int op_cyc = 0, rdy_cnt = 0, last_cnt = 0, idle_run = 0;
    bit after_done = 1'b0;
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        op_cyc = 0; rdy_cnt = 0; last_cnt = 0; idle_run = 0; after_done = 1'b0;
      end else begin
        if (bus.busy) begin
          check("gnt_onehot_busy", $countones(bus.gnt), 1);
          if (after_done && gap_chk) check("idle_gap", idle_run, 1);
          after_done = 1'b0;
          idle_run = 0;
        end else begin
          idle_run++;
        end
        if (bus.gnt != 2'b00) op_cyc++;
        if (bus.ready_zj) rdy_cnt++;
        if (bus.zj_last) last_cnt++;
        if (bus.done != 2'b00) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", {30'd0, bus.done}, 0);
          end else begin
            e = exp_q.pop_front();
            check("done_who", {30'd0, bus.done}, {30'd0, e});
            check("gnt_at_done", {30'd0, bus.gnt}, {30'd0, e});
            check("ready_count", rdy_cnt, N);
            check("last_count", last_cnt, 1);
            check("op_cycles", op_cyc, N + DELTA + 2);
          end
          op_cyc = 0; rdy_cnt = 0; last_cnt = 0; after_done = 1'b1;
        end
      end
    end
  end

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done != 2'b00) seen = 1'b1;
    end
    if (!seen) check("wait_done_timeout", 0, 1);
  endtask

  task automatic wait_feed_idx(input logic [7:0] idx);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.load_x && bus.digit_idx == idx) seen = 1'b1;
    end
    if (!seen) check("wait_idx_timeout", 0, 1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_outputs", {15'd0, snap}, 0);
    rst = 1'b0;
    p_model = 1'b0;
  endtask

  initial begin
    logic [1:0] pat;
    bit w;
    int cnt;
    rst = 1'b1;
    bus.req = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_state", {15'd0, snap}, 0);
    rst = 1'b0;

    // Single request, cycle-exact timeline.
    bus.req = 2'b01;
    exp_q.push_back(2'b01);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check($sformatf("single_cyc%0d", k), {15'd0, snap}, {15'd0, exp_vec(k)});
      if (k == 14) bus.req = 2'b00;
    end

    // Contention after reset: 0,1,0,1 with one idle cycle between operations.
    apply_reset();
    gap_chk = 1'b1;
    bus.req = 2'b11;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    for (int op = 0; op < 4; op++) wait_done();
    bus.req = 2'b00;
    gap_chk = 1'b0;
    @(negedge clk);

    // Requester 1 drops its request mid-FEED; operation still completes.
    bus.req = 2'b10;
    exp_q.push_back(2'b10);
    wait_feed_idx(8'd3);
    bus.req = 2'b00;
    wait_done();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) cnt++;
    end
    check("no_regrant", cnt, 0);

    // Reset at digit_idx 5 aborts without done; requester 0 wins afterwards.
    bus.req = 2'b01;
    wait_feed_idx(8'd5);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {15'd0, snap}, 0);
    rst = 1'b0;
    bus.req = 2'b11;
    exp_q.push_back(2'b01);
    wait_done();
    bus.req = 2'b00;
    @(negedge clk);

    // Random request patterns against a round-robin pointer model.
    apply_reset();
    for (int t = 0; t < 100; t++) begin
      pat = 2'($urandom_range(0, 3));
      if (pat == 2'b00) begin
        bus.req = 2'b00;
        repeat (3) @(negedge clk);
        check("idle_no_req", {31'd0, bus.busy}, 0);
      end else begin
        bus.req = pat;
        w = pat[p_model] ? p_model : ~p_model;
        exp_q.push_back(w ? 2'b10 : 2'b01);
        p_model = ~w;
        wait_done();
        bus.req = 2'b00;
        @(negedge clk);
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/msdf_mul_sched.md
MSDF_MUL_SCHED -- requirements
Module: msdf_mul_sched

Interface
REQ-001 The block SHALL have parameter N, default 9, giving digits per operand and per result.
REQ-002 The block SHALL have parameter DELTA, default 3, giving the online delay of the shared serial-serial multiplier; legal range is 1 <= DELTA < N.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req, input, 2 bits: per-requester operation request, level, held until the matching done.
REQ-006 The block SHALL have port gnt, output, 2 bits: one-hot grant, which also drives the operand/result mux select.
REQ-007 The block SHALL have port dp_clear, output, 1 bit: one-cycle pulse that clears the multiplier registers (LX, LY, CA_REG, WC/WS, PJ).
REQ-008 The block SHALL have port load_x, output, 1 bit: operand digit enable; the granted requester presents digit x_j, y_j while it is high.
REQ-009 The block SHALL have port ready_zj, output, 1 bit: result digit z_j valid.
REQ-010 The block SHALL have port zj_last, output, 1 bit: high with the final (N-th) valid result digit.
REQ-011 The block SHALL have port digit_idx, output, 8 bits: index of the current FEED or FLUSH cycle, starting at 0.
REQ-012 The block SHALL have port done, output, 2 bits: one-cycle completion pulse to the served requester.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have five states: IDLE, CLEAR, FEED, FLUSH and DONE; all outputs SHALL be registered.
REQ-015 In IDLE, if any req bit is high, the FSM SHALL move to CLEAR, latch the winner and set gnt to the winner on the next edge.
REQ-016 Arbitration SHALL be round-robin: pointer p names the preferred requester; if req[p] is high, p wins, otherwise the other requester wins.
REQ-017 On entry to DONE, p SHALL become the index of the requester not just served.
REQ-018 CLEAR SHALL last 1 cycle with dp_clear=1 and load_x=0, then go to FEED.
REQ-019 FEED SHALL last exactly N cycles with load_x=1 and digit_idx 0..N-1, then go to FLUSH.
REQ-020 FLUSH SHALL last exactly DELTA cycles with load_x=0 (zero digits fed) and digit_idx N..N+DELTA-1, then go to DONE.
REQ-021 ready_zj SHALL be high exactly when digit_idx is in DELTA..N+DELTA-1, giving N consecutive cycles.
REQ-022 zj_last SHALL be high only when digit_idx = N+DELTA-1.
REQ-023 DONE SHALL last 1 cycle with done[winner]=1 and gnt still held, then go to IDLE with gnt=0.
REQ-024 gnt SHALL stay constant and one-hot from CLEAR through DONE and SHALL be 0 in IDLE.
REQ-025 Deassertion of req during an operation SHALL be ignored; the operation SHALL run to DONE.
REQ-026 A request asserted while busy SHALL wait; it is arbitrated in the next IDLE cycle, so there is at least 1 IDLE cycle between operations.
REQ-027 digit_idx SHALL be 0 outside FEED and FLUSH; the internal counter SHALL never exceed N+DELTA-1, with no wrap.
REQ-028 done and gnt SHALL never assert for a requester whose req was low at arbitration.

Reset
REQ-029 When rst=1 at a clock edge, state SHALL become IDLE and p SHALL become 0, from any state including mid-FEED or mid-FLUSH.
REQ-030 When rst=1 at a clock edge, gnt, dp_clear, load_x, ready_zj, zj_last, digit_idx, done and busy SHALL all become 0, with no done pulse for the aborted operation.
REQ-031 The first arbitration after reset release SHALL prefer requester 0.

Verification (N=9, DELTA=3)
REQ-032 Single request: req=01 in IDLE at edge t -> gnt=01 and dp_clear=1 at t+1; load_x high t+2..t+10; ready_zj high t+5..t+13; zj_last at t+13; done=01 at t+14; gnt=00 and busy=0 at t+15.
REQ-033 Contention: req=11 held after reset -> grant order 0,1,0,1; every operation lasts 14 cycles with gnt high; exactly 1 IDLE cycle between operations.
REQ-034 Request drop: req[1] falls during FEED -> operation completes and done=10 is still pulsed; no re-grant to requester 1 while its req is 0.
REQ-035 Reset mid-operation: rst=1 for 1 cycle at digit_idx=5 -> all outputs 0 on the next edge, no done pulse; with req=11 afterwards, requester 0 is granted first.
REQ-036 Count check: across 100 random request patterns, exactly N ready_zj cycles and exactly one zj_last per done pulse, and gnt is never non-one-hot while busy.
